// File: rtl/accel_pkg.sv
// Shared constants and types for the factorial accelerator: register map,
// FSM state encoding and result width.
package accel_pkg;

    localparam int RESULT_W = 32;

    localparam logic [3:0] ADDR_N_RES0 = 4'd0;
    localparam logic [3:0] ADDR_RES1   = 4'd1;
    localparam logic [3:0] ADDR_RES2   = 4'd2;
    localparam logic [3:0] ADDR_RES3   = 4'd3;
    localparam logic [3:0] ADDR_STATUS = 4'd4;
    localparam logic [3:0] ADDR_START  = 4'd5;
    localparam logic [3:0] ADDR_INTEN  = 4'd6;
    localparam logic [3:0] ADDR_DONE   = 4'd7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/fact_datapath.sv
// Factorial datapath: running product acc, down-counter cnt and the 32x8
// multiplier that folds cnt into acc on every step.
module fact_datapath
    import accel_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [7:0]          n_value,
    output logic [RESULT_W-1:0] acc,
    output logic                cnt_gt1
);

    logic [RESULT_W-1:0] acc_r;
    logic [7:0]          cnt_r;
    logic [RESULT_W-1:0] mul_s;

    // Product is deliberately truncated: results wrap modulo 2^32.
    assign mul_s   = acc_r * {{(RESULT_W-8){1'b0}}, cnt_r};
    assign acc     = acc_r;
    assign cnt_gt1 = (cnt_r > 8'd1);

    // Accumulator and counter update: load on start, step while cnt > 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {RESULT_W{1'b0}};
            cnt_r <= 8'd0;
        end else if (load) begin
            acc_r <= {{(RESULT_W-1){1'b0}}, 1'b1};
            cnt_r <= n_value;
        end else if (step) begin
            acc_r <= mul_s;
            cnt_r <= cnt_r - 8'd1;
        end
    end

endmodule

// File: rtl/factorial_accelerator.sv
// Memory-mapped factorial coprocessor: bus decoder, host registers and FSM.
// Optional sticky overflow flag (status bit 1) is built when ACCEL_OVF_EN is defined.
module factorial_accelerator
    import accel_pkg::*;
#(
    parameter int dataWidth = 8,
    parameter int addrWidth = 4
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 readmem,
    input  logic                 writemem,
    input  logic [addrWidth-1:0] address,
    input  logic [dataWidth-1:0] dataIn,
    output logic [dataWidth-1:0] dataOut,
    output logic                 memDataReady,
    output logic                 interrupt
);

    state_t              state_r;
    logic [7:0]          n_r;
    logic                int_en_r;
    logic                done_r;
    logic [RESULT_W-1:0] result_r;

    logic                wr_s;
    logic                rd_s;
    logic                wr_n_s;
    logic                wr_start_s;
    logic                wr_inten_s;
    logic                clr_done_s;
    logic                busy_s;
    logic                load_s;
    logic                step_s;
    logic                cnt_gt1_s;
    logic                ovf_s;
    logic [RESULT_W-1:0] acc_s;
    logic [dataWidth-1:0] rdata_s;

    assign wr_s       = cs & writemem;
    assign rd_s       = cs & readmem;
    assign wr_n_s     = wr_s & (address == ADDR_N_RES0);
    assign wr_start_s = wr_s & (address == ADDR_START);
    assign wr_inten_s = wr_s & (address == ADDR_INTEN);
    assign clr_done_s = wr_s & (address == ADDR_DONE) & ~dataIn[0];

    assign busy_s    = (state_r == CALC);
    assign load_s    = (state_r == IDLE) & wr_start_s;
    assign step_s    = busy_s & cnt_gt1_s;
    assign interrupt = done_r & int_en_r;

    fact_datapath u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .step    (step_s),
        .n_value (n_r),
        .acc     (acc_s),
        .cnt_gt1 (cnt_gt1_s)
    );

`ifdef ACCEL_OVF_EN
    logic ovf_r;

    // Sticky overflow: re-evaluated only when a computation is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (load_s) begin
            ovf_r <= (n_r > 8'd12);
        end
    end

    assign ovf_s = ovf_r;
`else
    assign ovf_s = 1'b0;
`endif

    // Host-writable registers; n may change mid-run since the datapath latched its copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_r      <= 8'd0;
            int_en_r <= 1'b0;
        end else begin
            if (wr_n_s) begin
                n_r <= dataIn[7:0];
            end
            if (wr_inten_s) begin
                int_en_r <= dataIn[0];
            end
        end
    end

    // Control FSM; completion takes priority over a same-cycle host clear of done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            done_r   <= 1'b0;
            result_r <= {RESULT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (wr_start_s) begin
                        state_r <= CALC;
                        done_r  <= 1'b0;
                    end else if (clr_done_s) begin
                        done_r <= 1'b0;
                    end
                end
                CALC: begin
                    if (cnt_gt1_s) begin
                        if (clr_done_s) begin
                            done_r <= 1'b0;
                        end
                    end else begin
                        result_r <= acc_s;
                        done_r   <= 1'b1;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Read mux over current register values, so a same-cycle write is not visible.
    always_comb begin
        rdata_s = 8'h00;
        case (address)
            ADDR_N_RES0: rdata_s = result_r[7:0];
            ADDR_RES1:   rdata_s = result_r[15:8];
            ADDR_RES2:   rdata_s = result_r[23:16];
            ADDR_RES3:   rdata_s = result_r[31:24];
            ADDR_STATUS: rdata_s = {6'd0, ovf_s, busy_s};
            ADDR_INTEN:  rdata_s = {7'd0, int_en_r};
            ADDR_DONE:   rdata_s = {7'd0, done_r};
            default:     rdata_s = 8'h00;
        endcase
    end

    // Registered read port: data valid the cycle after the read is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut      <= 8'h00;
            memDataReady <= 1'b0;
        end else begin
            memDataReady <= rd_s;
            if (rd_s) begin
                dataOut <= rdata_s;
            end
        end
    end

endmodule

// File: tb/tb_factorial_accelerator.sv
// Directed self-checking bench for factorial_accelerator; bus driven and
// sampled on the falling clock edge.
module tb_factorial_accelerator;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       readmem;
    logic       writemem;
    logic [3:0] address;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       memDataReady;
    logic       interrupt;

    int checks = 0;
    int errors = 0;

    factorial_accelerator dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .readmem      (readmem),
        .writemem     (writemem),
        .address      (address),
        .dataIn       (dataIn),
        .dataOut      (dataOut),
        .memDataReady (memDataReady),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    // Both bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; writemem = 1'b1; address = a; dataIn = d;
        @(negedge clk);
        cs = 1'b0; writemem = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d, output logic rdy);
        cs = 1'b1; readmem = 1'b1; address = a;
        @(negedge clk);
        d = dataOut; rdy = memDataReady;
        cs = 1'b0; readmem = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic       r;
        rst = 1'b1; cs = 1'b0; readmem = 1'b0; writemem = 1'b0;
        address = 4'd0; dataIn = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({dataOut, memDataReady, interrupt} !== 10'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%b/%b expected 00/0/0", dataOut, memDataReady, interrupt);
        end
        rst = 1'b0;
        bus_read(4'd4, d, r);
        checks++;
        if (d !== 8'h00 || r !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got %h rdy %b expected 00 rdy 1", d, r);
        end
        bus_read(4'd0, d, r);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL reset_result: got %h expected 00", d);
        end
    endtask

    task automatic test_n10;
        logic [7:0]  d;
        logic        r;
        logic [31:0] exp_res = 32'h00375F00;
        bus_write(4'd0, 8'd10);
        bus_write(4'd6, 8'h01);
        bus_write(4'd5, 8'h00);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (interrupt !== (i == 10)) begin
                errors++;
                $display("FAIL n10_irq_cycle%0d: got %b expected %b", i, interrupt, (i == 10));
            end
        end
        for (int b = 0; b < 4; b++) begin
            bus_read(4'(b), d, r);
            checks++;
            if (d !== exp_res[8*b +: 8] || r !== 1'b1) begin
                errors++;
                $display("FAIL n10_byte%0d: got %h rdy %b expected %h rdy 1", b, d, r, exp_res[8*b +: 8]);
            end
        end
        bus_read(4'd7, d, r);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL n10_done: got %h expected 01", d);
        end
        bus_read(4'd4, d, r);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL n10_status_idle: got %h expected 00", d);
        end
        @(negedge clk);
        checks++;
        if (memDataReady !== 1'b0 || dataOut !== 8'h00) begin
            errors++;
            $display("FAIL n10_no_read: got rdy %b data %h expected rdy 0 data 00", memDataReady, dataOut);
        end
    endtask

    task automatic test_clear;
        logic [7:0] d;
        logic       r;
        cs = 1'b1; readmem = 1'b1; writemem = 1'b1; address = 4'd7; dataIn = 8'h00;
        @(negedge clk);
        cs = 1'b0; readmem = 1'b0; writemem = 1'b0;
        checks++;
        if (dataOut !== 8'h01 || memDataReady !== 1'b1 || interrupt !== 1'b0) begin
            errors++;
            $display("FAIL clear_rw: got %h/%b irq %b expected 01/1 irq 0", dataOut, memDataReady, interrupt);
        end
        bus_write(4'd7, 8'h01);
        bus_read(4'd7, d, r);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL clear_done_read: got %h expected 00", d);
        end
    endtask

    task automatic test_small;
        logic [7:0] d;
        logic       r;
        bus_write(4'd6, 8'h00);
        for (int n = 0; n < 2; n++) begin
            bus_write(4'd0, 8'(n));
            bus_write(4'd5, 8'h00);
            bus_read(4'd7, d, r);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL small%0d_done_before: got %h expected 00", n, d);
            end
            bus_read(4'd7, d, r);
            checks++;
            if (d !== 8'h01 || interrupt !== 1'b0) begin
                errors++;
                $display("FAIL small%0d_done_after: got %h irq %b expected 01 irq 0", n, d, interrupt);
            end
            bus_read(4'd0, d, r);
            checks++;
            if (d !== 8'h01) begin
                errors++;
                $display("FAIL small%0d_result: got %h expected 01", n, d);
            end
        end
    endtask

    task automatic test_n13;
        logic [7:0]  d;
        logic        r;
        logic [31:0] exp_res = 32'h7328CC00; // 6227020800 mod 2^32 = 1932053504
        logic [7:0]  exp_status;
`ifdef ACCEL_OVF_EN
        exp_status = 8'h02;
`else
        exp_status = 8'h00;
`endif
        bus_write(4'd6, 8'h01);
        bus_write(4'd0, 8'd13);
        bus_write(4'd5, 8'h00);
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            checks++;
            if (interrupt !== (i == 13)) begin
                errors++;
                $display("FAIL n13_irq_cycle%0d: got %b expected %b", i, interrupt, (i == 13));
            end
        end
        for (int b = 0; b < 4; b++) begin
            bus_read(4'(b), d, r);
            checks++;
            if (d !== exp_res[8*b +: 8]) begin
                errors++;
                $display("FAIL n13_byte%0d: got %h expected %h", b, d, exp_res[8*b +: 8]);
            end
        end
        bus_read(4'd4, d, r);
        checks++;
        if (d !== exp_status) begin
            errors++;
            $display("FAIL n13_status: got %h expected %h", d, exp_status);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  d;
        logic        r;
        logic [31:0] exp_res = 32'h00375F00;
        bus_write(4'd7, 8'h00);
        bus_write(4'd0, 8'd10);
        bus_write(4'd5, 8'h00);
        bus_read(4'd4, d, r);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL b2b_status_busy: got %h expected 01", d);
        end
        @(negedge clk);
        bus_write(4'd5, 8'h00);
        bus_write(4'd0, 8'd3);
        for (int i = 5; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (interrupt !== (i == 10)) begin
                errors++;
                $display("FAIL b2b_irq_cycle%0d: got %b expected %b", i, interrupt, (i == 10));
            end
        end
        for (int b = 0; b < 4; b++) begin
            bus_read(4'(b), d, r);
            checks++;
            if (d !== exp_res[8*b +: 8]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h expected %h", b, d, exp_res[8*b +: 8]);
            end
        end
    endtask

    task automatic test_rst_mid;
        logic [7:0] d;
        logic       r;
        bus_read(4'd1, d, r);
        bus_write(4'd0, 8'd10);
        bus_write(4'd5, 8'h00);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({dataOut, memDataReady, interrupt} !== 10'h000) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h/%b/%b expected 00/0/0", dataOut, memDataReady, interrupt);
        end
        repeat (10) @(negedge clk);
        bus_read(4'd7, d, r);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_done: got %h expected 00", d);
        end
        bus_read(4'd6, d, r);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_inten: got %h expected 00", d);
        end
        bus_read(4'd1, d, r);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_result: got %h expected 00", d);
        end
        bus_write(4'd0, 8'd5);
        bus_write(4'd6, 8'h01);
        bus_write(4'd5, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (interrupt !== (i == 5)) begin
                errors++;
                $display("FAIL rst_fresh_irq_cycle%0d: got %b expected %b", i, interrupt, (i == 5));
            end
        end
        bus_read(4'd0, d, r);
        checks++;
        if (d !== 8'h78) begin
            errors++;
            $display("FAIL rst_fresh_result: got %h expected 78", d);
        end
    endtask

    task automatic test_unmapped;
        logic [7:0] d;
        logic       r;
        bus_write(4'd12, 8'hFF);
        bus_write(4'd5, 8'hFF);
        repeat (6) @(negedge clk);
        bus_read(4'd12, d, r);
        checks++;
        if (d !== 8'h00 || r !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_read: got %h rdy %b expected 00 rdy 1", d, r);
        end
        bus_read(4'd5, d, r);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL start_read: got %h expected 00", d);
        end
        bus_read(4'd6, d, r);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL unmapped_no_side_effect: got %h expected 01", d);
        end
    endtask

    initial begin
        test_reset();
        test_n10();
        test_clear();
        test_small();
        test_n13();
        test_back_to_back();
        test_rst_mid();
        test_unmapped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
